// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: serializes icache fill and dcache read/write requests
// onto a single-ported RAM. Data requests win by default. A starvation
// counter forces an instruction grant after STARVE_LIM consecutive data
// grants that were made while an instruction fetch was pending.
// Optional build macro: ARB_PERF_CNT_EN adds per-side completion counters
// on the icnt/dcnt outputs.
module cache_mem_arbiter #(
    parameter int WORD_W     = 32,
    parameter int STARVE_LIM = 4
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              iREN,
    input  logic [WORD_W-1:0] iaddr,
    output logic              iwait,
    output logic [WORD_W-1:0] iload,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [WORD_W-1:0] daddr,
    input  logic [WORD_W-1:0] dstore,
    output logic              dwait,
    output logic [WORD_W-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [WORD_W-1:0] ramaddr,
    output logic [WORD_W-1:0] ramstore,
    input  logic [WORD_W-1:0] ramload,
    input  logic [1:0]        ramstate,
    output logic              ram_err
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [31:0]       icnt,
    output logic [31:0]       dcnt
`endif
);

    typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;

    localparam logic [1:0]        RAM_ACCESS = 2'd2;
    localparam logic [1:0]        RAM_ERROR  = 2'd3;
    localparam logic [WORD_W-1:0] ERR_WORD   = WORD_W'(32'hBAD1BAD1);
    localparam logic [3:0]        LIM        = 4'(STARVE_LIM);

    state_t            state, next_state;
    logic [WORD_W-1:0] lat_addr, lat_store;
    logic              lat_wen;
    logic [3:0]        starve_cnt;
    logic              grab_i, grab_d;
    logic              ram_done, ram_fail;

    // ERROR counts as a completion so a faulty RAM never hangs a requester
    assign ram_fail = (ramstate == RAM_ERROR);
    assign ram_done = (ramstate == RAM_ACCESS) || ram_fail;

    // State register; reset abandons any grant without a completion pulse
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state <= IDLE;
        else       state <= next_state;
    end

    // Arbitration, RAM drive and completion pulses
    always_comb begin
        next_state = state;
        grab_i     = 1'b0;
        grab_d     = 1'b0;
        iwait      = 1'b1;
        dwait      = 1'b1;
        iload      = '0;
        dload      = '0;
        ramREN     = 1'b0;
        ramWEN     = 1'b0;
        ramaddr    = '0;
        ramstore   = '0;
        case (state)
            IDLE: begin
                if ((dREN || dWEN) && !(iREN && (starve_cnt == LIM))) begin
                    next_state = GNT_D;
                    grab_d     = 1'b1;
                end else if (iREN) begin
                    next_state = GNT_I;
                    grab_i     = 1'b1;
                end
            end
            GNT_I: begin
                ramREN  = 1'b1;
                ramaddr = lat_addr;
                if (ram_done) begin
                    iwait      = 1'b0;
                    iload      = ram_fail ? ERR_WORD : ramload;
                    next_state = IDLE;
                end
            end
            GNT_D: begin
                ramREN   = !lat_wen;
                ramWEN   = lat_wen;
                ramaddr  = lat_addr;
                ramstore = lat_store;
                if (ram_done) begin
                    dwait      = 1'b0;
                    dload      = ram_fail ? ERR_WORD : (lat_wen ? '0 : ramload);
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Capture the winning request so requester changes mid-grant are ignored
    always_ff @(posedge CLK) begin
        if (grab_d) begin
            lat_addr  <= daddr;
            lat_store <= dstore;
        end else if (grab_i) begin
            lat_addr  <= iaddr;
        end
    end

    // Write/read select for the data grant
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)       lat_wen <= 1'b0;
        else if (grab_d) lat_wen <= dWEN;
        else if (grab_i) lat_wen <= 1'b0;
    end

    // Consecutive data grants while a fetch waits; never exceeds LIM since
    // reaching it hands the next grant to the instruction side
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)       starve_cnt <= '0;
        else if (grab_d) starve_cnt <= iREN ? starve_cnt + 4'd1 : 4'd0;
        else if (grab_i) starve_cnt <= '0;
    end

    // Sticky RAM error flag, cleared only by reset
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)                              ram_err <= 1'b0;
        else if ((state != IDLE) && ram_fail)   ram_err <= 1'b1;
    end

`ifdef ARB_PERF_CNT_EN
    // Completed transactions per side, wrapping at 2^32
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            icnt <= '0;
            dcnt <= '0;
        end else begin
            if (!iwait) icnt <= icnt + 32'd1;
            if (!dwait) dcnt <= dcnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Testbench for cache_mem_arbiter: directed scenarios followed by randomized
// traffic checked against a transaction-level reference model.
module tb_cache_mem_arbiter;
    localparam int W   = 32;
    localparam int LIM = 4;
    localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;

    logic          CLK = 1'b0;
    logic          nRST;
    logic          iREN, dREN, dWEN;
    logic [W-1:0]  iaddr, daddr, dstore, ramload;
    logic [1:0]    ramstate;
    logic          iwait, dwait, ramREN, ramWEN, ram_err;
    logic [W-1:0]  iload, dload, ramaddr, ramstore;
`ifdef ARB_PERF_CNT_EN
    logic [31:0]   icnt, dcnt;
`endif

    cache_mem_arbiter #(.WORD_W(W), .STARVE_LIM(LIM)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .ram_err(ram_err)
`ifdef ARB_PERF_CNT_EN
        , .icnt(icnt), .dcnt(dcnt)
`endif
    );

    always #5 CLK = ~CLK;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic ram(input logic [1:0] st, input logic [W-1:0] ld);
        ramstate = st;
        ramload  = ld;
        #1;
    endtask

    // Memory contents seen by the RAM (written from the DUT's RAM port) and
    // by the reference model (written from requester intent)
    logic [31:0] ram_mem [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];

    function automatic logic [31:0] init_val(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h13579BDF;
    endfunction
    function automatic logic [31:0] ram_rd(input logic [31:0] a);
        return ram_mem.exists(a) ? ram_mem[a] : init_val(a);
    endfunction
    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
    endfunction

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, time %0t expected below 300000", $time);
        $fatal(1);
    end

    initial begin
        int starve, phase, busy, n_i, n_d;
        bit act, side_d, c_wr, done;
        logic [31:0] c_addr, c_data;

        nRST = 1'b0; iREN = 0; dREN = 0; dWEN = 0;
        iaddr = '0; daddr = '0; dstore = '0; ramload = '0; ramstate = FREE;
        #12;
        check("rst_iwait",    iwait, 1);
        check("rst_dwait",    dwait, 1);
        check("rst_ramREN",   ramREN, 0);
        check("rst_ramWEN",   ramWEN, 0);
        check("rst_ram_err",  ram_err, 0);
        check("rst_iload",    iload, 0);
        check("rst_dload",    dload, 0);
        check("rst_ramaddr",  ramaddr, 0);
        check("rst_ramstore", ramstore, 0);
        tick;
        nRST = 1'b1;

        // Single instruction fetch
        iREN = 1; iaddr = 32'h40;
        tick; ram(FREE, '0);
        check("t1_ramREN", ramREN, 1);
        check("t1_ramaddr", ramaddr, 32'h40);
        check("t1_iwait_hold", iwait, 1);
        tick; ram(ACCESS, 32'h8C220004);
        check("t1_iwait", iwait, 0);
        check("t1_iload", iload, 32'h8C220004);
        check("t1_dwait", dwait, 1);
        tick; iREN = 0; ram(FREE, '0);
        check("t1_idle_ren", ramREN, 0);
        check("t1_idle_iwait", iwait, 1);

        // Simultaneous requests: data first, then instruction
        iREN = 1; iaddr = 32'h10; dREN = 1; daddr = 32'h200;
        tick; ram(ACCESS, 32'h11112222);
        check("t2_d_addr", ramaddr, 32'h200);
        check("t2_d_ren", ramREN, 1);
        check("t2_dwait", dwait, 0);
        check("t2_dload", dload, 32'h11112222);
        check("t2_iwait_hi", iwait, 1);
        tick; dREN = 0; ram(FREE, '0);
        check("t2_gap", {ramREN, ramWEN}, 0);
        tick; ram(ACCESS, 32'h33334444);
        check("t2_i_addr", ramaddr, 32'h10);
        check("t2_iwait", iwait, 0);
        check("t2_iload", iload, 32'h33334444);
        check("t2_dwait_hi", dwait, 1);
        tick; iREN = 0; ram(FREE, '0);

        // Starvation: four data writes, then the fetch, then data wins again
        iREN = 1; iaddr = 32'h44; dWEN = 1;
        for (int g = 0; g < 6; g++) begin
            daddr = 32'h100 + 32'(g * 4); dstore = 32'(g);
            tick; ram(ACCESS, 32'hCAFE0000 + 32'(g));
            if (g == 4) begin
                check("t3_i_ren", ramREN, 1);
                check("t3_i_addr", ramaddr, 32'h44);
                check("t3_iwait", iwait, 0);
            end else begin
                check("t3_d_wen", ramWEN, 1);
                check("t3_d_addr", ramaddr, 32'h100 + 32'(g * 4));
                check("t3_dwait", dwait, 0);
                check("t3_iwait_hi", iwait, 1);
            end
            tick; ram(FREE, '0);
        end
        iREN = 0; dWEN = 0;

        // Write with BUSY stretch; requester drops and changes inputs mid-grant
        tick;
        dWEN = 1; daddr = 32'h80; dstore = 32'hDEADBEEF;
        tick;
        dWEN = 0; daddr = '0; dstore = 32'h12345678;
        for (int k = 0; k < 4; k++) begin
            ram((k < 3) ? BUSY : ACCESS, '0);
            check("t4_wen", ramWEN, 1);
            check("t4_ren", ramREN, 0);
            check("t4_addr", ramaddr, 32'h80);
            check("t4_store", ramstore, 32'hDEADBEEF);
            check("t4_dwait", dwait, (k == 3) ? 0 : 1);
            tick;
        end
        ram(FREE, '0);
        check("t4_idle_wen", ramWEN, 0);

        // RAM error on a fetch
        iREN = 1; iaddr = 32'h60;
        tick; ram(ERROR, 32'h55);
        check("t5_iwait", iwait, 0);
        check("t5_iload", iload, 32'hBAD1BAD1);
        check("t5_err_pre", ram_err, 0);
        tick; iREN = 0; ram(FREE, '0);
        check("t5_err", ram_err, 1);
        check("t5_iwait_hi", iwait, 1);
        repeat (3) tick;
        check("t5_err_sticky", ram_err, 1);

        // Reset in the middle of a data grant
        dREN = 1; daddr = 32'h300;
        tick; ram(BUSY, '0);
        check("t6_ren", ramREN, 1);
        check("t6_addr", ramaddr, 32'h300);
        #2 nRST = 0; #1;
        check("t6_rst_ren", ramREN, 0);
        check("t6_rst_addr", ramaddr, 0);
        check("t6_rst_dwait", dwait, 1);
        check("t6_rst_err", ram_err, 0);
        tick; ram(ACCESS, 32'h99);
        check("t6_no_pulse", dwait, 1);
        nRST = 1; dREN = 0; iREN = 1; iaddr = 32'h70; ram(FREE, '0);
        tick; ram(ACCESS, 32'h77);
        check("t6_next_addr", ramaddr, 32'h70);
        check("t6_next_iwait", iwait, 0);
        check("t6_next_iload", iload, 32'h77);
        tick; iREN = 0; ram(FREE, '0);

        // Randomized traffic against the reference model
        starve = 0; phase = 0; busy = 0; n_i = 0; n_d = 0;
        act = 0; side_d = 0; c_wr = 0; c_addr = '0; c_data = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(posedge CLK); #1;
            if (phase == 0) begin
                if ((dREN || dWEN) && !(iREN && starve == LIM)) begin
                    act = 1; side_d = 1; c_addr = daddr; c_wr = dWEN; c_data = dstore;
                    starve = iREN ? starve + 1 : 0;
                end else if (iREN) begin
                    act = 1; side_d = 0; c_addr = iaddr; c_wr = 0;
                    starve = 0;
                end else begin
                    act = 0;
                end
                if (act) busy = $urandom_range(0, 3);
            end else if (phase == 2) begin
                act = 0;
            end
            check("r_ren", ramREN, {31'b0, act && !c_wr});
            check("r_wen", ramWEN, {31'b0, act && c_wr});
            if (act) check("r_addr", ramaddr, c_addr);
            if (act && c_wr) check("r_store", ramstore, c_data);

            done = 0;
            if (act) begin
                if (busy > 0) begin
                    ramstate = BUSY; busy--;
                end else begin
                    ramstate = ACCESS; done = 1;
                end
                ramload = c_wr ? $urandom : ram_rd(ramaddr);
                if (done && ramWEN) ram_mem[ramaddr] = ramstore;
            end else begin
                ramstate = 2'($urandom_range(0, 2));
                ramload  = $urandom;
            end

            @(negedge CLK);
            check("r_iwait", iwait, {31'b0, !(done && !side_d)});
            check("r_dwait", dwait, {31'b0, !(done && side_d)});
            if (done && !side_d) begin
                check("r_iload", iload, ref_rd(c_addr));
                n_i++;
                iREN = 0;
            end
            if (done && side_d) begin
                if (c_wr) ref_mem[c_addr] = c_data;
                else      check("r_dload", dload, ref_rd(c_addr));
                n_d++;
                dREN = 0; dWEN = 0;
            end
            phase = done ? 2 : (act ? 1 : 0);

            if (!iREN && $urandom_range(0, 2) == 0) begin
                iREN = 1; iaddr = 32'($urandom_range(0, 15)) << 2;
            end
            if (!dREN && !dWEN && $urandom_range(0, 1) == 0) begin
                if ($urandom_range(0, 1) == 1) dWEN = 1;
                else                            dREN = 1;
                daddr  = 32'($urandom_range(0, 15)) << 2;
                dstore = $urandom;
            end
        end

`ifdef ARB_PERF_CNT_EN
        check("perf_icnt", icnt, 32'(1 + n_i));
        check("perf_dcnt", dcnt, 32'(n_d));
`endif
        check("r_no_err", ram_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
